// File: rtl/noc_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter_if
//   Bundle of the arbiter's request side, output channel and observability.
//
//   Handshake rule for both channels: a packet moves on a rising clk edge
//   exactly when its valid and ready are both 1 at that edge. A valid packet
//   stays unchanged until it is taken. Ready may depend combinationally on
//   valid. It never waits for valid to be registered first.
//
//   Signals
//     i_data        numPE*TotalWidth  requester k packet at [k*TotalWidth +: TotalWidth]
//     i_data_valid  numPE             requester k offers a packet
//     o_data_ready  numPE             one-hot accept back to the requesters
//     o_data        TotalWidth        registered output packet
//     o_data_valid  1                 o_data holds a packet
//     i_data_ready  1                 downstream takes o_data
//     o_grant_id    IdWidth           requester that loaded the current o_data
//     o_pkt_count   32                packets delivered downstream (wrapping)
//     dbg_locked    1                 burst FSM is LOCKED to dbg_owner
//     dbg_owner     IdWidth           current burst owner (meaningful when locked)
//     dbg_ptr       IdWidth           round-robin search start
//
//   Modports
//     slave   the arbiter
//     master  the requesters plus the downstream sink (the environment)
// -----------------------------------------------------------------------------
interface noc_rr_arbiter_if #(
    parameter int numPE      = 4,
    parameter int TotalWidth = 35
);
    localparam int IdWidth = $clog2(numPE);

    logic [numPE*TotalWidth-1:0] i_data;
    logic [numPE-1:0]            i_data_valid;
    logic [numPE-1:0]            o_data_ready;
    logic [TotalWidth-1:0]       o_data;
    logic                        o_data_valid;
    logic                        i_data_ready;
    logic [IdWidth-1:0]          o_grant_id;
    logic [31:0]                 o_pkt_count;
    logic                        dbg_locked;
    logic [IdWidth-1:0]          dbg_owner;
    logic [IdWidth-1:0]          dbg_ptr;

    modport slave (
        input  i_data, i_data_valid, i_data_ready,
        output o_data_ready, o_data, o_data_valid, o_grant_id, o_pkt_count,
        output dbg_locked, dbg_owner, dbg_ptr
    );

    modport master (
        output i_data, i_data_valid, i_data_ready,
        input  o_data_ready, o_data, o_data_valid, o_grant_id, o_pkt_count,
        input  dbg_locked, dbg_owner, dbg_ptr
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
//   Lets numPE requesters share one NoC output channel. Arbitration is
//   round-robin, with an optional burst lock of up to BurstLen packets per
//   owner. The output stage is a single register and can sustain one packet
//   per cycle. Packets pass through bit for bit. The destination field is
//   never looked at.
//
//   Ports
//     clk   clock, every register updates on its rising edge
//     rst   synchronous, active-high reset; wins over any other event
//     bus   noc_rr_arbiter_if.slave (requests, output channel, debug)
//
//   Burst FSM
//     OPEN    no owner. A load from g locks g. With BurstLen==1 it instead
//             moves ptr past g and stays OPEN.
//     LOCKED  owner keeps the grant while it is valid and burst_cnt<BurstLen.
//             On the last burst packet, or when the owner is idle at a load
//             opportunity, ptr moves past the owner and the FSM reopens.
//             While stalled, nothing changes.
// -----------------------------------------------------------------------------
module noc_rr_arbiter #(
    parameter int numPE        = 4,
    parameter int AddressWidth = 2,
    parameter int DataWidth    = 32,
    parameter int TotalWidth   = 35,
    parameter int BurstLen     = 1
) (
    input  logic              clk,
    input  logic              rst,
    noc_rr_arbiter_if.slave   bus
);
    localparam int IDW   = $clog2(numPE);
    localparam int CNT_W = $clog2(BurstLen + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BurstLen);

    // Reject parameter sets that cannot describe a packet layout or a rotation.
    if (numPE < 2) begin : g_bad_num_pe
        $error("noc_rr_arbiter: numPE must be at least 2");
    end
    if (BurstLen < 1) begin : g_bad_burst
        $error("noc_rr_arbiter: BurstLen must be at least 1");
    end
    if (TotalWidth < DataWidth + AddressWidth) begin : g_bad_width
        $error("noc_rr_arbiter: TotalWidth smaller than data plus address fields");
    end

    typedef enum logic {
        S_OPEN   = 1'b0,
        S_LOCKED = 1'b1
    } burst_state_e;

    burst_state_e          state;
    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        owner;
    logic [CNT_W-1:0]      burst_cnt;

    logic [TotalWidth-1:0] data_q;
    logic                  valid_q;
    logic [IDW-1:0]        id_q;
    logic [31:0]           count_q;

    logic                  can_load;
    logic                  owner_hold;
    logic [IDW-1:0]        search_base;
    logic                  grant_valid;
    logic [IDW-1:0]        grant_idx;
    logic [numPE-1:0]      ready_vec;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
        if (x == IDW'(numPE - 1)) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    // The output register can take a new packet when it is empty or being
    // drained in this same cycle.
    assign can_load = !valid_q || bus.i_data_ready;

    // Grant selection. An owner that has dropped valid gives up the lock
    // this cycle. The search then starts just past it, so the others can
    // be served without a dead cycle.
    always_comb begin
        logic [IDW-1:0] cand_idx;
        int             cand;
        owner_hold  = (state == S_LOCKED) && bus.i_data_valid[owner] &&
                      (burst_cnt < BURST_MAX);
        search_base = (state == S_LOCKED) ? wrap_inc(owner) : ptr;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        if (owner_hold) begin
            grant_valid = 1'b1;
            grant_idx   = owner;
        end else begin
            // Walk from the far end so the candidate nearest search_base wins.
            for (int i = numPE - 1; i >= 0; i--) begin
                cand = int'(search_base) + i;
                if (cand >= numPE) begin
                    cand = cand - numPE;
                end
                cand_idx = IDW'(cand);
                if (bus.i_data_valid[cand_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

    // Accept is one-hot and purely combinational. It is forced low during
    // reset so nothing is consumed while the state is being cleared.
    always_comb begin
        ready_vec = '0;
        if (!rst && can_load && grant_valid) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OPEN;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            count_q   <= '0;
        end else begin
            if (valid_q && bus.i_data_ready) begin
                count_q <= count_q + 32'd1;
            end

            if (can_load) begin
                // Output register: load the granted packet, or go empty after a drain.
                if (grant_valid) begin
                    data_q  <= bus.i_data[grant_idx*TotalWidth +: TotalWidth];
                    valid_q <= 1'b1;
                    id_q    <= grant_idx;
                end else begin
                    valid_q <= 1'b0;
                end

                // Burst FSM advances only at a load opportunity.
                if (owner_hold) begin
                    if (burst_cnt + 1'b1 == BURST_MAX) begin
                        state     <= S_OPEN;
                        burst_cnt <= '0;
                        ptr       <= wrap_inc(owner);
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end else if (grant_valid) begin
                    if (BurstLen == 1) begin
                        state <= S_OPEN;
                        ptr   <= wrap_inc(grant_idx);
                    end else begin
                        state     <= S_LOCKED;
                        owner     <= grant_idx;
                        burst_cnt <= CNT_W'(1);
                    end
                end else if (state == S_LOCKED) begin
                    state     <= S_OPEN;
                    burst_cnt <= '0;
                    ptr       <= wrap_inc(owner);
                end
            end
        end
    end

    assign bus.o_data_ready = ready_vec;
    assign bus.o_data       = data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_grant_id   = id_q;
    assign bus.o_pkt_count  = count_q;
    assign bus.dbg_locked   = (state == S_LOCKED);
    assign bus.dbg_owner    = owner;
    assign bus.dbg_ptr      = ptr;
endmodule
